// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath width, ALU opcodes, branch conditions and
// the ID/EX pipeline register layout.
package rv32i_pkg;

   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] word_t;
   typedef logic [4:0]      reg_idx_t;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SLL  = 4'd1;
   localparam logic [3:0] ALU_SLT  = 4'd2;
   localparam logic [3:0] ALU_SLTU = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SRL  = 4'd5;
   localparam logic [3:0] ALU_OR   = 4'd6;
   localparam logic [3:0] ALU_AND  = 4'd7;
   localparam logic [3:0] ALU_SUB  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;

   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BLT  = 3'b100;
   localparam logic [2:0] BR_BGE  = 3'b101;
   localparam logic [2:0] BR_BLTU = 3'b110;
   localparam logic [2:0] BR_BGEU = 3'b111;
   // Not a funct3 branch encoding; the ALU never reports Z for it.
   localparam logic [2:0] BR_NONE = 3'b010;

   typedef struct packed {
      logic       valid;
      word_t      pc;
      reg_idx_t   rs1;
      reg_idx_t   rs2;
      word_t      rs1_data;
      word_t      rs2_data;
      reg_idx_t   rd;
      word_t      imm;
      logic [3:0] alu_op;
      logic [2:0] branch;
      logic       is_branch;
      logic       use_imm;
      logic       use_pc;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
   } ex_regs_t;

   function automatic ex_regs_t bubble_regs();
      ex_regs_t r;
      r        = '0;
      r.branch = BR_NONE;
      return r;
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-ID/EX bus: the decoded instruction flows down, stall_id flows back.
interface id_ex_stage_if;
   import rv32i_pkg::*;

   logic       id_valid;
   word_t      id_pc;
   reg_idx_t   id_rs1;
   reg_idx_t   id_rs2;
   word_t      id_rs1_data;
   word_t      id_rs2_data;
   reg_idx_t   id_rd;
   word_t      id_imm;
   logic [3:0] id_alu_op;
   logic [2:0] id_branch;
   logic       id_is_branch;
   logic       id_use_imm;
   logic       id_use_pc;
   logic       id_mem_read;
   logic       id_mem_write;
   logic       id_reg_write;
   logic       id_uses_rs1;
   logic       id_uses_rs2;
   logic       stall_id;

   modport master (
      output id_valid, id_pc, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_rd,
             id_imm, id_alu_op, id_branch, id_is_branch, id_use_imm, id_use_pc,
             id_mem_read, id_mem_write, id_reg_write, id_uses_rs1, id_uses_rs2,
      input  stall_id
   );

   modport slave (
      input  id_valid, id_pc, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_rd,
             id_imm, id_alu_op, id_branch, id_is_branch, id_use_imm, id_use_pc,
             id_mem_read, id_mem_write, id_reg_write, id_uses_rs1, id_uses_rs2,
      output stall_id
   );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding for one source register: EX/MEM, then MEM/WB, then the
// value read at decode. x0 always reads zero.
module fwd_mux
   import rv32i_pkg::*;
(
   input  reg_idx_t src,
   input  word_t    reg_data,
   input  reg_idx_t exm_rd,
   input  logic     exm_reg_write,
   input  word_t    exm_result,
   input  reg_idx_t mwb_rd,
   input  logic     mwb_reg_write,
   input  word_t    mwb_result,
   output word_t    data
);

   always_comb begin
      data = reg_data;
      if (src == 5'd0) begin
         data = '0;
      end else if (exm_reg_write && exm_rd == src) begin
         data = exm_result;
      end else if (mwb_reg_write && mwb_rd == src) begin
         data = mwb_result;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: load-use bubble insertion, flush,
// and forwarded operand selection.
module id_ex_stage
   import rv32i_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   id_ex_stage_if.slave       dec,
   input  logic               flush,
   input  reg_idx_t           exm_rd,
   input  logic               exm_reg_write,
   input  word_t              exm_result,
   input  reg_idx_t           mwb_rd,
   input  logic               mwb_reg_write,
   input  word_t              mwb_result,
   output logic               ex_valid,
   output word_t              ex_A,
   output word_t              ex_B,
   output logic [3:0]         ex_opcode,
   output logic [2:0]         ex_branch,
   output logic               ex_is_branch,
   output logic               ex_mem_read,
   output logic               ex_mem_write,
   output logic               ex_reg_write,
   output reg_idx_t           ex_rd,
   output word_t              ex_pc,
   output word_t              ex_store_data
);

   ex_regs_t ex_reg;
   ex_regs_t ex_next;
   logic     haz;
   word_t    fwd_rs1;
   word_t    fwd_rs2;

   assign haz = dec.id_valid && ex_reg.valid && ex_reg.mem_read && (ex_reg.rd != 5'd0) &&
                ((dec.id_uses_rs1 && dec.id_rs1 == ex_reg.rd) ||
                 (dec.id_uses_rs2 && dec.id_rs2 == ex_reg.rd));

   // A flush kills whatever decode holds, so there is nothing left to stall for.
   assign dec.stall_id = haz && !flush && !rst;

   always_comb begin
      ex_next = bubble_regs();
      if (!flush && !haz && dec.id_valid) begin
         ex_next.valid     = 1'b1;
         ex_next.pc        = dec.id_pc;
         ex_next.rs1       = dec.id_rs1;
         ex_next.rs2       = dec.id_rs2;
         ex_next.rs1_data  = dec.id_rs1_data;
         ex_next.rs2_data  = dec.id_rs2_data;
         ex_next.rd        = dec.id_rd;
         ex_next.imm       = dec.id_imm;
         ex_next.alu_op    = dec.id_alu_op;
         ex_next.branch    = dec.id_is_branch ? dec.id_branch : BR_NONE;
         ex_next.is_branch = dec.id_is_branch;
         ex_next.use_imm   = dec.id_use_imm;
         ex_next.use_pc    = dec.id_use_pc;
         ex_next.mem_read  = dec.id_mem_read;
         ex_next.mem_write = dec.id_mem_write;
         ex_next.reg_write = dec.id_reg_write;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_reg <= bubble_regs();
      end else begin
         ex_reg <= ex_next;
      end
   end

   fwd_mux u_fwd_rs1 (
      .src           (ex_reg.rs1),
      .reg_data      (ex_reg.rs1_data),
      .exm_rd        (exm_rd),
      .exm_reg_write (exm_reg_write),
      .exm_result    (exm_result),
      .mwb_rd        (mwb_rd),
      .mwb_reg_write (mwb_reg_write),
      .mwb_result    (mwb_result),
      .data          (fwd_rs1)
   );

   fwd_mux u_fwd_rs2 (
      .src           (ex_reg.rs2),
      .reg_data      (ex_reg.rs2_data),
      .exm_rd        (exm_rd),
      .exm_reg_write (exm_reg_write),
      .exm_result    (exm_result),
      .mwb_rd        (mwb_rd),
      .mwb_reg_write (mwb_reg_write),
      .mwb_result    (mwb_result),
      .data          (fwd_rs2)
   );

   assign ex_valid      = ex_reg.valid;
   assign ex_A          = ex_reg.use_pc ? ex_reg.pc : fwd_rs1;
   assign ex_B          = ex_reg.use_imm ? ex_reg.imm : fwd_rs2;
   assign ex_store_data = fwd_rs2;
   assign ex_opcode     = ex_reg.alu_op;
   assign ex_branch     = ex_reg.branch;
   assign ex_is_branch  = ex_reg.is_branch;
   assign ex_mem_read   = ex_reg.mem_read;
   assign ex_mem_write  = ex_reg.mem_write;
   assign ex_reg_write  = ex_reg.reg_write;
   assign ex_rd         = ex_reg.rd;
   assign ex_pc         = ex_reg.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed checks of the ID/EX stage: reset, forwarding priority, x0, load-use
// stall, flush-over-stall, operand select and branch/bubble controls.
module tb_id_ex_stage;
   import rv32i_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   reg_idx_t   exm_rd;
   logic       exm_reg_write;
   word_t      exm_result;
   reg_idx_t   mwb_rd;
   logic       mwb_reg_write;
   word_t      mwb_result;
   logic       ex_valid;
   word_t      ex_A;
   word_t      ex_B;
   logic [3:0] ex_opcode;
   logic [2:0] ex_branch;
   logic       ex_is_branch;
   logic       ex_mem_read;
   logic       ex_mem_write;
   logic       ex_reg_write;
   reg_idx_t   ex_rd;
   word_t      ex_pc;
   word_t      ex_store_data;

   int vectors = 0;
   int miscompares = 0;

   id_ex_stage_if dec ();

   id_ex_stage dut (
      .clk           (clk),
      .rst           (rst),
      .dec           (dec.slave),
      .flush         (flush),
      .exm_rd        (exm_rd),
      .exm_reg_write (exm_reg_write),
      .exm_result    (exm_result),
      .mwb_rd        (mwb_rd),
      .mwb_reg_write (mwb_reg_write),
      .mwb_result    (mwb_result),
      .ex_valid      (ex_valid),
      .ex_A          (ex_A),
      .ex_B          (ex_B),
      .ex_opcode     (ex_opcode),
      .ex_branch     (ex_branch),
      .ex_is_branch  (ex_is_branch),
      .ex_mem_read   (ex_mem_read),
      .ex_mem_write  (ex_mem_write),
      .ex_reg_write  (ex_reg_write),
      .ex_rd         (ex_rd),
      .ex_pc         (ex_pc),
      .ex_store_data (ex_store_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_instr();
      dec.id_valid = 0; dec.id_pc = '0; dec.id_rs1 = '0; dec.id_rs2 = '0;
      dec.id_rs1_data = '0; dec.id_rs2_data = '0; dec.id_rd = '0; dec.id_imm = '0;
      dec.id_alu_op = '0; dec.id_branch = '0; dec.id_is_branch = 0;
      dec.id_use_imm = 0; dec.id_use_pc = 0; dec.id_mem_read = 0;
      dec.id_mem_write = 0; dec.id_reg_write = 0; dec.id_uses_rs1 = 0; dec.id_uses_rs2 = 0;
   endtask

   task automatic clear_fwd();
      exm_rd = '0; exm_reg_write = 0; exm_result = '0;
      mwb_rd = '0; mwb_reg_write = 0; mwb_result = '0;
   endtask

   // R-type: rd = rs1 op rs2
   task automatic put_rtype(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] d1,
                            input logic [4:0] rs2, input logic [31:0] d2, input logic [3:0] op);
      clear_instr();
      dec.id_valid = 1; dec.id_rd = rd; dec.id_rs1 = rs1; dec.id_rs1_data = d1;
      dec.id_rs2 = rs2; dec.id_rs2_data = d2; dec.id_alu_op = op;
      dec.id_reg_write = 1; dec.id_uses_rs1 = 1; dec.id_uses_rs2 = 1;
   endtask

   task automatic put_load(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] d1);
      clear_instr();
      dec.id_valid = 1; dec.id_rd = rd; dec.id_rs1 = rs1; dec.id_rs1_data = d1;
      dec.id_imm = 32'd4; dec.id_use_imm = 1; dec.id_mem_read = 1;
      dec.id_reg_write = 1; dec.id_uses_rs1 = 1;
   endtask

   initial begin
      rst = 1; flush = 0;
      clear_fwd();
      put_rtype(5'd2, 5'd1, 32'h7, 5'd0, 32'h0, ALU_ADD);

      // reset held for two edges with a valid instruction at decode
      step();
      check("rst1_valid", 32'(ex_valid), 32'd0);
      check("rst1_branch", 32'(ex_branch), 32'(BR_NONE));
      check("rst1_stall", 32'(dec.stall_id), 32'd0);
      step();
      check("rst2_valid", 32'(ex_valid), 32'd0);
      check("rst2_A", ex_A, 32'd0);
      check("rst2_regwr", 32'(ex_reg_write), 32'd0);
      rst = 0;
      step();
      check("first_valid", 32'(ex_valid), 32'd1);
      check("first_A", ex_A, 32'h7);
      check("first_rd", 32'(ex_rd), 32'd2);

      // forwarding priority on rs1=5, rs2=6 feeding store data
      put_rtype(5'd7, 5'd5, 32'h11, 5'd6, 32'h66, ALU_SUB);
      step();
      exm_rd = 5'd5; exm_reg_write = 1; exm_result = 32'hAAAA;
      mwb_rd = 5'd5; mwb_reg_write = 1; mwb_result = 32'hBBBB;
      #1 check("fwd_exm_A", ex_A, 32'hAAAA);
      exm_rd = 5'd0;
      #1 check("fwd_mwb_A", ex_A, 32'hBBBB);
      mwb_reg_write = 0;
      #1 check("fwd_none_A", ex_A, 32'h11);
      check("fwd_none_B", ex_B, 32'h66);
      check("opcode_sub", 32'(ex_opcode), 32'(ALU_SUB));
      exm_rd = 5'd6; exm_reg_write = 1; exm_result = 32'h99;
      #1 check("fwd_exm_B", ex_B, 32'h99);
      clear_fwd();

      // x0 never forwarded
      put_rtype(5'd8, 5'd1, 32'h5, 5'd0, 32'h0, ALU_ADD);
      step();
      exm_rd = 5'd0; exm_reg_write = 1; exm_result = 32'h1234;
      #1 check("x0_B", ex_B, 32'h0);
      check("x0_store", ex_store_data, 32'h0);
      clear_fwd();

      // store data is forwarded rs2 even when B takes the immediate
      clear_instr();
      dec.id_valid = 1; dec.id_rs1 = 5'd1; dec.id_rs1_data = 32'h1000;
      dec.id_rs2 = 5'd6; dec.id_rs2_data = 32'h66; dec.id_imm = 32'h44;
      dec.id_use_imm = 1; dec.id_mem_write = 1; dec.id_uses_rs1 = 1; dec.id_uses_rs2 = 1;
      step();
      exm_rd = 5'd6; exm_reg_write = 1; exm_result = 32'h99;
      #1 check("sw_B_imm", ex_B, 32'h44);
      check("sw_store_fwd", ex_store_data, 32'h99);
      check("sw_memwr", 32'(ex_mem_write), 32'd1);
      clear_fwd();

      // load-use: lw x3 then add x4,x3,x1
      put_load(5'd3, 5'd2, 32'h200);
      step();
      check("lw_memrd", 32'(ex_mem_read), 32'd1);
      check("lw_B", ex_B, 32'd4);
      put_rtype(5'd4, 5'd3, 32'hDEAD, 5'd1, 32'h10, ALU_ADD);
      #1 check("lu_stall", 32'(dec.stall_id), 32'd1);
      step();
      check("lu_bubble_valid", 32'(ex_valid), 32'd0);
      check("lu_bubble_regwr", 32'(ex_reg_write), 32'd0);
      check("lu_bubble_branch", 32'(ex_branch), 32'(BR_NONE));
      check("lu_stall_once", 32'(dec.stall_id), 32'd0);
      mwb_rd = 5'd3; mwb_reg_write = 1; mwb_result = 32'h777;
      step();
      check("lu_add_valid", 32'(ex_valid), 32'd1);
      check("lu_add_A_mwb", ex_A, 32'h777);
      check("lu_add_B", ex_B, 32'h10);
      check("lu_add_rd", 32'(ex_rd), 32'd4);
      clear_fwd();

      // flush coincident with a load-use hazard
      put_load(5'd3, 5'd2, 32'h200);
      step();
      put_rtype(5'd4, 5'd3, 32'h0, 5'd1, 32'h10, ALU_ADD);
      flush = 1;
      #1 check("fl_stall", 32'(dec.stall_id), 32'd0);
      step();
      flush = 0;
      check("fl_valid", 32'(ex_valid), 32'd0);
      check("fl_regwr", 32'(ex_reg_write), 32'd0);

      // auipc: A=pc, B=imm
      clear_instr();
      dec.id_valid = 1; dec.id_pc = 32'h100; dec.id_imm = 32'h2000; dec.id_rd = 5'd9;
      dec.id_use_pc = 1; dec.id_use_imm = 1; dec.id_reg_write = 1; dec.id_alu_op = ALU_ADD;
      step();
      check("auipc_A", ex_A, 32'h100);
      check("auipc_B", ex_B, 32'h2000);
      check("auipc_op", 32'(ex_opcode), 32'(ALU_ADD));
      check("auipc_pc", ex_pc, 32'h100);

      // branch passes funct3 through; the same controls with id_valid=0 do not
      put_rtype(5'd0, 5'd1, 32'h3, 5'd2, 32'h4, ALU_SUB);
      dec.id_reg_write = 0; dec.id_is_branch = 1; dec.id_branch = BR_BNE;
      step();
      check("bne_branch", 32'(ex_branch), 32'(BR_BNE));
      check("bne_isbr", 32'(ex_is_branch), 32'd1);
      dec.id_valid = 0;
      step();
      check("inv_branch", 32'(ex_branch), 32'(BR_NONE));
      check("inv_isbr", 32'(ex_is_branch), 32'd0);
      check("inv_opcode", 32'(ex_opcode), 32'd0);

      // reset while stalled discards the held instruction
      put_load(5'd3, 5'd2, 32'h200);
      step();
      put_rtype(5'd4, 5'd3, 32'h0, 5'd1, 32'h10, ALU_ADD);
      #1 check("rs_stall_pre", 32'(dec.stall_id), 32'd1);
      rst = 1;
      #1 check("rs_stall_rst", 32'(dec.stall_id), 32'd0);
      step();
      check("rs_valid", 32'(ex_valid), 32'd0);
      check("rs_memrd", 32'(ex_mem_read), 32'd0);
      rst = 0;
      step();
      check("rs_reissue_valid", 32'(ex_valid), 32'd1);
      check("rs_reissue_rd", 32'(ex_rd), 32'd4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
